pipe_reg_da: RTL and testbench
==============================

Name: pipe_reg_da

Overview:
- Decode-to-ALU (D→A) pipeline register.
- Consumes the hazard unit's nop/stall request and inserts a bubble into the A stage while holding fetch/decode.
- Its A-stage outputs (is_write_A, is_load_A, reg_c_select_A) feed back into the hazard unit.
- Also handles branch flush, downstream stall and a stall-watchdog.

Parameters:
- REG_SELECT, 5, register-select width.
- DATA_WIDTH, 32, operand/immediate width.
- OP_WIDTH, 4, ALU opcode width.
- MAX_STALL, 15, consecutive o_stall_FD cycles tolerated before the watchdog fires; must be ≥1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid_D  in  1  decode stage holds a real instruction.
- i_op_D  in  OP_WIDTH  ALU opcode.
- i_is_cmp_D / i_is_load_D / i_is_write_D  in  1 each  decode control flags.
- i_reg_a_select_D, i_reg_b_select_D, i_reg_c_select_D  in  REG_SELECT each  source/destination selects.
- i_data_a_D, i_data_b_D, i_imm_D  in  DATA_WIDTH each  operands and immediate.
- i_nop  in  1  hazard-unit stall request.
- i_flush  in  1  branch redirect; kill decode instruction.
- i_stall_A  in  1  downstream A stage busy; hold register.
- o_stall_FD  out  1  hold fetch and decode registers (combinational).
- o_valid_A  out  1  A stage holds a real instruction.
- o_op_A  out  OP_WIDTH.
- o_is_cmp_A / o_is_load_A / o_is_write_A  out  1 each.
- o_reg_a_select_A, o_reg_b_select_A, o_reg_c_select_A  out  REG_SELECT each.
- o_data_a_A, o_data_b_A, o_imm_A  out  DATA_WIDTH each.
- o_deadlock  out  1  sticky watchdog flag.
- o_bubble_cnt  out  32  bubbles inserted (see Optional Feature).

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - All A-stage outputs are 0 (bubble).
  - Watchdog counter is 0 and o_deadlock is 0.
  - o_bubble_cnt is 0.
- Effective hazard: hz = i_nop & i_valid_D. A nop with an invalid decode slot is ignored.
- o_stall_FD = (hz | i_stall_A) & ~i_flush. It is purely combinational with no register latency, and is 0 while reset is asserted.
- Per-edge action, in priority order:
  - (1) reset;
  - (2) i_flush: load bubble. Flush wins over both stalls.
  - (3) i_stall_A: hold all A outputs unchanged.
  - (4) hz: load bubble.
  - (5) otherwise load all D inputs. o_valid_A = i_valid_D.
- Bubble definition:
  - o_valid_A, o_is_cmp_A, o_is_load_A and o_is_write_A are 0.
  - All selects, data and opcode fields are 0.
  - A bubble can never match a real hazard, because reg 0 with write=0 never triggers one.
- Load latency is 1 cycle: D inputs sampled at edge N appear on A outputs after edge N.
- A flushed or invalid instruction (i_valid_D=0 when loaded) forces is_write/is_load/is_cmp_A to 0 regardless of the D flags.
- Watchdog:
  - The 4-bit-minimum counter (width = clog2(MAX_STALL+1)) increments each cycle o_stall_FD=1 and clears to 0 on any cycle o_stall_FD=0.
  - When the counter reaches MAX_STALL while o_stall_FD is still 1, o_deadlock is set on that edge.
  - o_deadlock stays 1 until reset. The counter saturates at MAX_STALL and never wraps.
- Simultaneous hz & i_stall_A:
  - The register holds; no bubble is inserted and no bubble is counted.
  - o_stall_FD=1.
- Reset mid-stall: all state clears on that edge. o_stall_FD follows its inputs combinationally after reset deasserts.

Optional Feature:
- Macro: PIPE_DA_BUBBLE_CNT_EN.
- Defined:
  - o_bubble_cnt is a 32-bit counter that increments on every edge where case (4) hz-bubble is taken.
  - Flush bubbles and held cycles are not counted.
  - The counter saturates at 0xFFFF_FFFF and clears only on reset.
- Undefined: no counter logic is built, and o_bubble_cnt is tied to 32'h0.

Test Plan:
- Reset: i_rst_n=0 for 2 cycles with random D inputs -> all A outputs 0, o_deadlock=0, o_bubble_cnt=0.
- Normal flow: valid instr op=3, a=1, b=2, c=5, data_a=0x10, i_nop=0 -> next cycle o_valid_A=1, o_op_A=3, o_reg_c_select_A=5, o_data_a_A=0x10; o_stall_FD=0.
- Load-use bubble: A holds load with c=5; D reads a=5 and i_nop=1 -> o_stall_FD=1 same cycle; next edge A=bubble (o_valid_A=0, o_reg_c_select_A=0); bubble_cnt=1 if enabled; D then loads on the following edge.
- Flush priority: i_nop=1, i_stall_A=1, i_flush=1 together -> o_stall_FD=0; next edge A=bubble; bubble_cnt unchanged.
- Downstream hold: i_stall_A=1 for 3 cycles with A holding c=7 -> A outputs unchanged all 3 cycles; o_stall_FD=1; no count.
- Watchdog: MAX_STALL=15, i_stall_A=1 for 16 cycles -> o_deadlock rises after the 15th stalled edge; stays 1 after i_stall_A drops; clears only on reset.

Source files
------------

// File: rtl/pipe_reg_da.sv
// pipe_reg_da -- decode-to-ALU (D->A) pipeline register.
//
// Captures the decode-stage instruction into the A stage. It also handles
// hazard bubbles, branch flushes, downstream holds and a stall watchdog.
//
// Edge priority: reset, flush (bubble), downstream stall (hold),
// hazard (bubble), normal load.
//
// Optional feature macro: PIPE_DA_BUBBLE_CNT_EN.
//   When defined, o_bubble_cnt counts hazard bubbles and saturates.
//   When undefined, o_bubble_cnt is tied to zero.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), synchronous active-low reset
//   i_valid_D .. i_imm_D  decode-stage instruction fields
//   i_nop               hazard-unit stall request (qualified by i_valid_D)
//   i_flush             branch redirect, kills the decode instruction
//   i_stall_A           downstream busy, hold the A register
//   o_stall_FD          combinational hold request to fetch/decode
//   o_valid_A .. o_imm_A  A-stage instruction fields
//   o_deadlock          sticky watchdog flag
//   o_bubble_cnt        hazard bubbles inserted (zero when feature is off)
module pipe_reg_da #(
  parameter int REG_SELECT = 5,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int MAX_STALL  = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid_D,
  input  logic [OP_WIDTH-1:0]   i_op_D,
  input  logic                  i_is_cmp_D,
  input  logic                  i_is_load_D,
  input  logic                  i_is_write_D,
  input  logic [REG_SELECT-1:0] i_reg_a_select_D,
  input  logic [REG_SELECT-1:0] i_reg_b_select_D,
  input  logic [REG_SELECT-1:0] i_reg_c_select_D,
  input  logic [DATA_WIDTH-1:0] i_data_a_D,
  input  logic [DATA_WIDTH-1:0] i_data_b_D,
  input  logic [DATA_WIDTH-1:0] i_imm_D,
  input  logic                  i_nop,
  input  logic                  i_flush,
  input  logic                  i_stall_A,
  output logic                  o_stall_FD,
  output logic                  o_valid_A,
  output logic [OP_WIDTH-1:0]   o_op_A,
  output logic                  o_is_cmp_A,
  output logic                  o_is_load_A,
  output logic                  o_is_write_A,
  output logic [REG_SELECT-1:0] o_reg_a_select_A,
  output logic [REG_SELECT-1:0] o_reg_b_select_A,
  output logic [REG_SELECT-1:0] o_reg_c_select_A,
  output logic [DATA_WIDTH-1:0] o_data_a_A,
  output logic [DATA_WIDTH-1:0] o_data_b_A,
  output logic [DATA_WIDTH-1:0] o_imm_A,
  output logic                  o_deadlock,
  output logic [31:0]           o_bubble_cnt
);

  // Watchdog counter is at least 4 bits wide.
  localparam int CNT_RAW = $clog2(MAX_STALL + 1);
  localparam int CNT_W   = (CNT_RAW < 4) ? 4 : CNT_RAW;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STALL);

  logic                  hz;
  logic                  stall_fd;
  logic                  hz_bubble;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      cnt_next;
  logic                  deadlock_reg;

  logic                  valid_reg;
  logic [OP_WIDTH-1:0]   op_reg;
  logic                  cmp_reg;
  logic                  load_reg;
  logic                  write_reg;
  logic [REG_SELECT-1:0] sel_a_reg;
  logic [REG_SELECT-1:0] sel_b_reg;
  logic [REG_SELECT-1:0] sel_c_reg;
  logic [DATA_WIDTH-1:0] data_a_reg;
  logic [DATA_WIDTH-1:0] data_b_reg;
  logic [DATA_WIDTH-1:0] imm_reg;

  // A nop request is ignored when the decode slot is empty.
  assign hz = i_nop & i_valid_D;

  // Forced low during reset so fetch/decode are never held by stale inputs.
  assign stall_fd = i_rst_n & (hz | i_stall_A) & ~i_flush;
  assign o_stall_FD = stall_fd;

  // A hazard bubble is taken only when neither flush nor hold wins.
  assign hz_bubble = ~i_flush & ~i_stall_A & hz;

  // The counter saturates at MAX_STALL instead of wrapping.
  assign cnt_next = (cnt_reg == MAX_C) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_reg    <= 1'b0;
      op_reg       <= '0;
      cmp_reg      <= 1'b0;
      load_reg     <= 1'b0;
      write_reg    <= 1'b0;
      sel_a_reg    <= '0;
      sel_b_reg    <= '0;
      sel_c_reg    <= '0;
      data_a_reg   <= '0;
      data_b_reg   <= '0;
      imm_reg      <= '0;
      cnt_reg      <= '0;
      deadlock_reg <= 1'b0;
    end else begin
      if (i_flush || (!i_stall_A && hz)) begin
        // Bubble: reg 0 with write=0 can never raise a hazard downstream.
        valid_reg  <= 1'b0;
        op_reg     <= '0;
        cmp_reg    <= 1'b0;
        load_reg   <= 1'b0;
        write_reg  <= 1'b0;
        sel_a_reg  <= '0;
        sel_b_reg  <= '0;
        sel_c_reg  <= '0;
        data_a_reg <= '0;
        data_b_reg <= '0;
        imm_reg    <= '0;
      end else if (!i_stall_A) begin
        // Control flags are qualified by valid so an empty slot never
        // writes, loads or compares.
        valid_reg  <= i_valid_D;
        op_reg     <= i_op_D;
        cmp_reg    <= i_is_cmp_D & i_valid_D;
        load_reg   <= i_is_load_D & i_valid_D;
        write_reg  <= i_is_write_D & i_valid_D;
        sel_a_reg  <= i_reg_a_select_D;
        sel_b_reg  <= i_reg_b_select_D;
        sel_c_reg  <= i_reg_c_select_D;
        data_a_reg <= i_data_a_D;
        data_b_reg <= i_data_b_D;
        imm_reg    <= i_imm_D;
      end

      if (stall_fd) begin
        cnt_reg <= cnt_next;
        // Fires on the edge where the count reaches MAX_STALL.
        if (cnt_next == MAX_C) begin
          deadlock_reg <= 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

`ifdef PIPE_DA_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bubble_cnt_reg <= 32'h0;
    end else if (hz_bubble && (bubble_cnt_reg != 32'hFFFF_FFFF)) begin
      bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
    end
  end

  assign o_bubble_cnt = bubble_cnt_reg;
`else
  assign o_bubble_cnt = 32'h0;
`endif

  assign o_valid_A        = valid_reg;
  assign o_op_A           = op_reg;
  assign o_is_cmp_A       = cmp_reg;
  assign o_is_load_A      = load_reg;
  assign o_is_write_A     = write_reg;
  assign o_reg_a_select_A = sel_a_reg;
  assign o_reg_b_select_A = sel_b_reg;
  assign o_reg_c_select_A = sel_c_reg;
  assign o_data_a_A       = data_a_reg;
  assign o_data_b_A       = data_b_reg;
  assign o_imm_A          = imm_reg;
  assign o_deadlock       = deadlock_reg;

endmodule

// File: tb/tb_pipe_reg_da.sv
// Self-checking bench for pipe_reg_da: a table of vectors with expected
// A-stage contents, queued at drive time and compared after the edge,
// plus hand-written reset, watchdog and reset-mid-stall sequences.
module tb_pipe_reg_da;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_d, cmp_d, load_d, write_d;
  logic [3:0]  op_d;
  logic [4:0]  sa_d, sb_d, sc_d;
  logic [31:0] da_d, db_d, imm_d;
  logic        nop, flush, stall_a;
  logic        stall_fd, valid_a, cmp_a, load_a, write_a, deadlock;
  logic [3:0]  op_a;
  logic [4:0]  sa_a, sb_a, sc_a;
  logic [31:0] da_a, db_a, imm_a, bubble_cnt;

  always #5 clk = ~clk;

  pipe_reg_da dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_D(valid_d), .i_op_D(op_d),
    .i_is_cmp_D(cmp_d), .i_is_load_D(load_d), .i_is_write_D(write_d),
    .i_reg_a_select_D(sa_d), .i_reg_b_select_D(sb_d), .i_reg_c_select_D(sc_d),
    .i_data_a_D(da_d), .i_data_b_D(db_d), .i_imm_D(imm_d),
    .i_nop(nop), .i_flush(flush), .i_stall_A(stall_a),
    .o_stall_FD(stall_fd), .o_valid_A(valid_a), .o_op_A(op_a),
    .o_is_cmp_A(cmp_a), .o_is_load_A(load_a), .o_is_write_A(write_a),
    .o_reg_a_select_A(sa_a), .o_reg_b_select_A(sb_a), .o_reg_c_select_A(sc_a),
    .o_data_a_A(da_a), .o_data_b_A(db_a), .o_imm_A(imm_a),
    .o_deadlock(deadlock), .o_bubble_cnt(bubble_cnt)
  );

  typedef struct packed {
    logic        v;
    logic [3:0]  op;
    logic        cmp, ld, wr;
    logic [4:0]  a, b, c;
    logic [31:0] da, db, imm;
  } astate_t;

  typedef struct {
    // stimulus
    logic v; logic [3:0] op; logic ld, wr; logic [4:0] a, c; logic [31:0] da;
    logic nop, fl, st;
    // expectations
    logic e_stall, e_bub, e_v; logic [3:0] e_op; logic e_ld, e_wr;
    logic [4:0] e_a, e_c; logic [31:0] e_da; logic bc_inc;
  } vec_t;

  typedef struct { astate_t a; logic [31:0] bc; } exp_t;

  vec_t    vecs[11];
  exp_t    sb_q[$];
  int      checks = 0;
  int      errors = 0;
  logic [31:0] exp_bc = 32'h0;

  function automatic vec_t mk(input logic v, input logic [3:0] op, input logic ld, wr,
                              input logic [4:0] a, c, input logic [31:0] da,
                              input logic nop, fl, st, e_stall, e_bub, e_v,
                              input logic [3:0] e_op, input logic e_ld, e_wr,
                              input logic [4:0] e_a, e_c, input logic [31:0] e_da,
                              input logic bc_inc);
    vec_t r;
    r.v = v; r.op = op; r.ld = ld; r.wr = wr; r.a = a; r.c = c; r.da = da;
    r.nop = nop; r.fl = fl; r.st = st;
    r.e_stall = e_stall; r.e_bub = e_bub; r.e_v = e_v; r.e_op = e_op;
    r.e_ld = e_ld; r.e_wr = e_wr; r.e_a = e_a; r.e_c = e_c; r.e_da = e_da;
    r.bc_inc = bc_inc;
    return r;
  endfunction

  // Expected A-stage record; b/db/imm/cmp are derived from the other fields
  // the same way the stimulus derives them.
  function automatic astate_t exp_a(input vec_t t);
    astate_t s;
    s = '0;
    if (!t.e_bub) begin
      s.v = t.e_v; s.op = t.e_op; s.cmp = t.e_v & t.e_op[0];
      s.ld = t.e_ld; s.wr = t.e_wr; s.a = t.e_a; s.b = t.e_c + 5'd1; s.c = t.e_c;
      s.da = t.e_da; s.db = t.e_da ^ 32'hFF; s.imm = t.e_da << 4;
    end
    return s;
  endfunction

  function automatic astate_t dut_a();
    astate_t s;
    s.v = valid_a; s.op = op_a; s.cmp = cmp_a; s.ld = load_a; s.wr = write_a;
    s.a = sa_a; s.b = sb_a; s.c = sc_a; s.da = da_a; s.db = db_a; s.imm = imm_a;
    return s;
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_a(input string name, input astate_t req);
    astate_t act;
    act = dut_a();
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got v=%0b op=%0h cmp=%0b ld=%0b wr=%0b a=%0d b=%0d c=%0d da=%h db=%h imm=%h expected v=%0b op=%0h cmp=%0b ld=%0b wr=%0b a=%0d b=%0d c=%0d da=%h db=%h imm=%h",
               name, act.v, act.op, act.cmp, act.ld, act.wr, act.a, act.b, act.c, act.da, act.db, act.imm,
               req.v, req.op, req.cmp, req.ld, req.wr, req.a, req.b, req.c, req.da, req.db, req.imm);
    end
  endtask

  task automatic drive_idle();
    valid_d = 1'b0; op_d = '0; cmp_d = 1'b0; load_d = 1'b0; write_d = 1'b0;
    sa_d = '0; sb_d = '0; sc_d = '0; da_d = '0; db_d = '0; imm_d = '0;
    nop = 1'b0; flush = 1'b0; stall_a = 1'b0;
  endtask

  task automatic drive_vec(input vec_t t);
    valid_d = t.v; op_d = t.op; cmp_d = t.op[0]; load_d = t.ld; write_d = t.wr;
    sa_d = t.a; sb_d = t.c + 5'd1; sc_d = t.c;
    da_d = t.da; db_d = t.da ^ 32'hFF; imm_d = t.da << 4;
    nop = t.nop; flush = t.fl; stall_a = t.st;
  endtask

  initial begin
    exp_t e;
    astate_t zero_a;
    zero_a = '0;

    //         v op ld wr a  c  da     nop fl st | stall bub v op ld wr a c da  bc
    vecs[0]  = mk(1, 3, 1, 1, 1, 5, 32'h10, 0, 0, 0, 0, 0, 1, 3, 1, 1, 1, 5, 32'h10, 0);
    vecs[1]  = mk(1, 2, 0, 1, 5, 6, 32'h20, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,  1);
    vecs[2]  = mk(1, 2, 0, 1, 5, 6, 32'h20, 0, 0, 0, 0, 0, 1, 2, 0, 1, 5, 6, 32'h20, 0);
    vecs[3]  = mk(1, 9, 1, 1, 4, 9, 32'h90, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,  0);
    vecs[4]  = mk(1, 4, 0, 1, 2, 7, 32'h70, 0, 0, 0, 0, 0, 1, 4, 0, 1, 2, 7, 32'h70, 0);
    vecs[5]  = mk(1, 8, 1, 1, 3, 8, 32'h80, 0, 0, 1, 1, 0, 1, 4, 0, 1, 2, 7, 32'h70, 0);
    vecs[6]  = vecs[5];
    vecs[7]  = vecs[5];
    vecs[8]  = mk(1, 8, 1, 1, 3, 8, 32'h80, 1, 0, 1, 1, 0, 1, 4, 0, 1, 2, 7, 32'h70, 0);
    vecs[9]  = mk(0, 5, 1, 1, 6, 3, 32'h33, 1, 0, 0, 0, 0, 0, 5, 0, 0, 6, 3, 32'h33, 0);
    vecs[10] = mk(1, 6, 1, 1, 3, 4, 32'h44, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,  1);

    // Reset with random decode inputs and an active hazard request.
    rst_n = 1'b0;
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      valid_d = 1'b1; op_d = 4'($urandom); write_d = 1'b1; load_d = 1'b1;
      sc_d = 5'($urandom); da_d = $urandom; nop = 1'b1;
      #1 check1("reset_stall_fd", {31'b0, stall_fd}, 32'h0);
    end
    @(posedge clk); #1;
    check_a("reset_a_state", zero_a);
    check1("reset_deadlock", {31'b0, deadlock}, 32'h0);
    check1("reset_bubble_cnt", bubble_cnt, 32'h0);
    $display("reset: a_valid=%0b deadlock=%0b bubble_cnt=%0d", valid_a, deadlock, bubble_cnt);

    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();

    // Table-driven flow through load, hazard, flush, hold and invalid slots.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #1 check1($sformatf("vec%0d_stall_fd", i), {31'b0, stall_fd}, {31'b0, vecs[i].e_stall});
`ifdef PIPE_DA_BUBBLE_CNT_EN
      if (vecs[i].bc_inc) exp_bc = exp_bc + 32'd1;
`endif
      e.a = exp_a(vecs[i]);
      e.bc = exp_bc;
      sb_q.push_back(e);
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL vec%0d_scoreboard: got empty queue expected one entry", i);
      end else begin
        e = sb_q.pop_front();
        check_a($sformatf("vec%0d_a_state", i), e.a);
        check1($sformatf("vec%0d_bubble_cnt", i), bubble_cnt, e.bc);
        check1($sformatf("vec%0d_deadlock", i), {31'b0, deadlock}, 32'h0);
      end
      $display("vec%0d: nop=%0b flush=%0b stall_a=%0b -> stall_fd=%0b valid_a=%0b op_a=%0h c_a=%0d bubble_cnt=%0d",
               i, nop, flush, stall_a, stall_fd, valid_a, op_a, sc_a, bubble_cnt);
    end

    // Watchdog: 16 downstream-stalled edges; the flag rises on the 15th.
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stall_a = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      check1($sformatf("wd_edge%0d", k), {31'b0, deadlock}, (k >= 15) ? 32'h1 : 32'h0);
      $display("watchdog edge %0d: stall_fd=%0b deadlock=%0b", k, stall_fd, deadlock);
    end
    @(negedge clk);
    stall_a = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check1($sformatf("wd_sticky%0d", k), {31'b0, deadlock}, 32'h1);
      $display("watchdog sticky %0d: stall_fd=%0b deadlock=%0b", k, stall_fd, deadlock);
    end

    // Reset asserted in the middle of a stall.
    @(negedge clk);
    stall_a = 1'b1;
    rst_n = 1'b0;
    #1 check1("rst_mid_stall_fd", {31'b0, stall_fd}, 32'h0);
    @(posedge clk); #1;
    check1("rst_mid_deadlock", {31'b0, deadlock}, 32'h0);
    check_a("rst_mid_a_state", zero_a);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check1("post_rst_stall_fd", {31'b0, stall_fd}, 32'h1);
    $display("reset mid-stall: stall_fd=%0b deadlock=%0b valid_a=%0b", stall_fd, deadlock, valid_a);

    @(negedge clk);
    drive_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
